// File: rtl/kgp_pkg.sv
// Shared types and helpers for the iterative KGP prefix adder.
// Carry-status encoding: K (kill) = 2'b00, P (propagate) = 2'b01,
// G (generate) = 2'b11. The value 2'b10 never appears internally.
package kgp_pkg;

  typedef logic [1:0] kgp_t;

  localparam kgp_t KGP_K = 2'b00;
  localparam kgp_t KGP_P = 2'b01;
  localparam kgp_t KGP_G = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_PREFIX = 2'b01,
    ST_DONE   = 2'b10
  } kgp_state_e;

  // Prefix operator: a propagating upper group takes the status of the lower group.
  function automatic kgp_t kgp_comb(input kgp_t hi, input kgp_t lo);
    return (hi == KGP_P) ? lo : hi;
  endfunction

  // Per-bit encode for bits above bit 0, which has the carry-in folded in separately.
  function automatic kgp_t kgp_encode(input logic a_bit, input logic b_bit);
    return (a_bit ^ b_bit) ? KGP_P : (a_bit ? KGP_G : KGP_K);
  endfunction

endpackage

// File: rtl/kgp_prefix_stage.sv
// One Kogge-Stone prefix level at distance 2^lvl_i over a W-entry KGP code vector.
// Purely combinational; the adder reuses a single instance for every level.
// Code i occupies bits [2*i+1:2*i] of the flat vectors.
module kgp_prefix_stage
  import kgp_pkg::*;
#(
  parameter  int W     = 64,
  localparam int LOG2W = $clog2(W)
) (
  input  logic [2*W-1:0]   codes_i,
  input  logic [LOG2W-1:0] lvl_i,
  output logic [2*W-1:0]   codes_o
);

  // Shift distance in bits is 2 * 2^lvl; the widest case (lvl = LOG2W-1) equals W.
  logic [LOG2W:0]   shamt_s;
  logic [2*W-1:0]   lo_vec_s;
  logic [W-1:0]     in_range_s;

  assign shamt_s  = (LOG2W+1)'(2) << lvl_i;
  assign lo_vec_s = codes_i << shamt_s;

  for (genvar i = 0; i < W; i++) begin : g_bit
    localparam logic [LOG2W:0] IDX = (LOG2W+1)'(i);
    // Bit i has a partner 2^lvl below it exactly when i >> lvl is non-zero.
    assign in_range_s[i]      = ((IDX >> lvl_i) != {(LOG2W+1){1'b0}});
    assign codes_o[2*i +: 2]  = in_range_s[i] ? kgp_comb(codes_i[2*i +: 2], lo_vec_s[2*i +: 2])
                                              : codes_i[2*i +: 2];
  end

endmodule

// File: rtl/kgp_seq_adder.sv
// Iterative parallel-prefix adder: encodes a/b/cin into KGP codes on accept,
// resolves one Kogge-Stone level per clock through a shared combine stage,
// then decodes sum/cout from the registered codes.
// Optional build macro KGP_SEQ_OVERFLOW_EN adds the signed-overflow output ovf.
module kgp_seq_adder
  import kgp_pkg::*;
#(
  parameter  int W     = 64,
  localparam int LOG2W = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef KGP_SEQ_OVERFLOW_EN
  ,
  output logic         ovf
`endif
);

  kgp_state_e         state_q;
  logic [LOG2W-1:0]   lvl_q;
  logic [2*W-1:0]     codes_q;
  logic [2*W-1:0]     codes_d;
  logic [W-1:0]       p_q;
  logic               cin_q;
  logic               out_valid_q;

  logic [W-1:0]       p_s;
  logic [2*W-1:0]     enc_s;
  logic [W-1:0]       carry_s;
  logic               accept_s;
  logic               lvl_last_s;

  // Handshake: idle always accepts; a finished result accepts new operands
  // in the same cycle the consumer takes the old one.
  assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept_s   = in_valid && in_ready;
  assign lvl_last_s = (lvl_q == LOG2W'(LOG2W-1));
  assign out_valid  = out_valid_q;
  assign p_s        = a ^ b;

  // Encode operands into per-bit KGP codes; bit 0 absorbs cin so it is never P.
  always_comb begin
    enc_s = {W{KGP_K}};
    for (int i = 1; i < W; i++) begin
      enc_s[2*i +: 2] = kgp_encode(a[i], b[i]);
    end
    enc_s[1:0] = p_s[0] ? (cin ? KGP_G : KGP_K) : (a[0] ? KGP_G : KGP_K);
  end

  kgp_prefix_stage #(.W(W)) u_stage (
    .codes_i (codes_q),
    .lvl_i   (lvl_q),
    .codes_o (codes_d)
  );

  // Control FSM plus datapath registers; a fresh capture always restarts at level 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lvl_q       <= {LOG2W{1'b0}};
      codes_q     <= {W{KGP_K}};
      p_q         <= {W{1'b0}};
      cin_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            codes_q <= enc_s;
            p_q     <= p_s;
            cin_q   <= cin;
            lvl_q   <= {LOG2W{1'b0}};
            state_q <= ST_PREFIX;
          end
        end
        ST_PREFIX: begin
          codes_q <= codes_d;
          lvl_q   <= lvl_q + LOG2W'(1);
          if (lvl_last_s) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              codes_q <= enc_s;
              p_q     <= p_s;
              cin_q   <= cin;
              lvl_q   <= {LOG2W{1'b0}};
              state_q <= ST_PREFIX;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          lvl_q       <= {LOG2W{1'b0}};
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Decode resolved group codes into carries: carry into bit i is G of group [i-1:0].
  always_comb begin
    carry_s    = {W{1'b0}};
    carry_s[0] = cin_q;
    for (int i = 1; i < W; i++) begin
      carry_s[i] = (codes_q[2*(i-1) +: 2] == KGP_G);
    end
  end

  assign sum  = p_q ^ carry_s;
  assign cout = (codes_q[2*W-1 -: 2] == KGP_G);

`ifdef KGP_SEQ_OVERFLOW_EN
  assign ovf  = carry_s[W-1] ^ cout;
`endif

endmodule

// File: tb/tb_kgp_seq_adder.sv
// Scoreboard bench for kgp_seq_adder (W=64): stimulus pushes expected results,
// an independent monitor pops and compares on every output handshake.
module tb_kgp_seq_adder;

  localparam int W = 64;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef KGP_SEQ_OVERFLOW_EN
  logic         ovf;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  logic rdy_mode = 1'b0;
  logic rdy_val  = 1'b1;

  kgp_seq_adder #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef KGP_SEQ_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Consumer ready: fixed value or random backpressure.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  // Monitor: pops the scoreboard on each accepted result and checks held outputs stay put.
  initial begin : monitor
    exp_t         e;
    logic         hold_pending;
    logic [W:0]   held;
    hold_pending = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          check("hold_valid", out_valid, 1);
          check("hold_stable", {cout, sum}, held);
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_result: got %0h with no pending operation at %0t", {cout, sum}, $time);
          end else begin
            e = sb_q.pop_front();
            check("sum", sum, e.sum);
            check("cout", cout, e.cout);
`ifdef KGP_SEQ_OVERFLOW_EN
            check("ovf", ovf, e.ovf);
`endif
          end
        end
        hold_pending = out_valid && !out_ready;
        held = {cout, sum};
      end
    end
  end

  // Present operands until accepted; expected result enters the scoreboard at accept.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input exp_t e);
    bit done = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = ta;
    b = tb_;
    cin = tc;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready low for 200 cycles expected accept");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = rand64();
    b = rand64();
    cin = ~cin;
  endtask

  task automatic dir(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                     input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    e.sum = es;
    e.cout = ec;
    e.ovf = eo;
    send(ta, tb_, tc, e);
  endtask

  // Counts negedges after an accept edge until out_valid; must be 7 for W=64.
  task automatic check_latency(input string name);
    int k = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (out_valid) begin
        k = j;
        break;
      end
    end
    check(name, k, 7);
  endtask

  task automatic wait_valid();
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("wait_valid", out_valid, 1);
  endtask

  task automatic wait_idle();
    for (int j = 0; j < 500; j++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !out_valid) break;
    end
    check("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    exp_t e;
    logic [W:0] full;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
`ifdef KGP_SEQ_OVERFLOW_EN
    check("rst_ovf", ovf, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors, first one also checks latency.
    rdy_mode = 1'b0;
    rdy_val = 1'b1;
    dir(64'h1, 64'h1, 1'b0, 64'h2, 1'b0, 1'b0);
    check_latency("latency_first");
    dir(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0);
    dir(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    dir(64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0);
    dir(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    dir(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1);
    dir(64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    dir(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    dir(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    wait_idle();

    // Backpressure in DONE with new operands waiting, then back-to-back capture.
    rdy_val = 1'b0;
    dir(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = rand64();
      b = rand64();
      cin = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    a = 64'h0123_4567_89AB_CDEF;
    b = 64'hFEDC_BA98_7654_3210;
    cin = 1'b1;
    rdy_val = 1'b1;
    @(negedge clk);
    check("b2b_in_ready", in_ready, 1);
    e.sum = 64'h0;
    e.cout = 1'b1;
    e.ovf = 1'b0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = rand64();
    b = rand64();
    check_latency("latency_b2b");
    wait_idle();

    // Reset while level 3 is pending: the operation must vanish.
    dir(64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 64'h0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    void'(sb_q.pop_back());
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("abort_no_result", out_valid, 0);
    end

    // Random operands with random consumer backpressure.
    rdy_mode = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = rand64();
      rb = rand64();
      rc = 1'($urandom_range(0, 1));
      if (n % 16 == 0) rb = ~ra;
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      e.sum = full[W-1:0];
      e.cout = full[W];
      e.ovf = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
      send(ra, rb, rc, e);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rdy_mode = 1'b0;
    rdy_val = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
